cge_pkt_fifo_sc: RTL and testbench
==================================

Name: cge_pkt_fifo_sc

Overview:
Single-clock, first-word-fall-through packet FIFO built on an inferred RAM. It is the storage core under the packet-FIFO wrapper when DUAL_CLOCK=0. The wrapper packs {tuser, data, sop, eop, mod} into one DWIDTH word; this block only stores and returns those words. It also supplies the full, empty and fill-level flags the wrapper uses for almost-full and free-space calculation.

Parameters:
- DWIDTH, 8: word width in bits.
- AWIDTH, 11: address width; depth = 2**AWIDTH words.
- SHOWAHEAD, "ON": "ON" selects first-word-fall-through; "OFF" selects a normal registered read.
- LPM_HINT, "RAM_BLOCK_TYPE=M20K": RAM-style hint string. It is a synthesis attribute only and has no functional effect.

Ports:
- clock, in, 1: single clock; everything is sampled on its rising edge.
- aclr_n, in, 1: asynchronous reset, active low.
- data, in, DWIDTH: write word.
- wrreq, in, 1: write request.
- rdreq, in, 1: read/pop request.
- q, out, DWIDTH: read word.
- empty, out, 1: FIFO holds 0 words.
- full, out, 1: FIFO holds 2**AWIDTH words.
- usedw, out, AWIDTH: stored word count modulo 2**AWIDTH.

Behaviour:
- Reset (aclr_n=0, asynchronous assert, synchronous release):
  - pointers and count are cleared;
  - empty=1, full=0, usedw=0, q=0.
  - Reset asserted mid-operation discards all contents immediately.
- Internal count: AWIDTH+1 bits, range 0..2**AWIDTH.
  - empty = (count==0); full = (count==2**AWIDTH).
  - Both flags are registered and change on the same edge as the count.
- usedw = count[AWIDTH-1:0]. It therefore reads 0 when full; consumers must qualify it with full.
- Write accepted = wrreq && !full. Accepted data is stored at the write pointer, which then increments and wraps modulo 2**AWIDTH.
- Read accepted = rdreq && !empty. The read pointer increments and wraps.
- Overflow and underflow protection:
  - a write while full is ignored, with no pointer, count or data change;
  - a read while empty is ignored.
- Simultaneous accepted write and read: count is unchanged.
  - When full, only the read is accepted.
  - When empty, only the write is accepted.
- SHOWAHEAD="ON":
  - q always shows the oldest stored word whenever empty=0.
  - A word written at edge N makes empty=0 and q valid after edge N (usable in cycle N+1); write-to-read latency is 1 cycle.
  - After an accepted read at edge N, q shows the next word after edge N, or empty=1 if none remains.
  - q is don't-care while empty=1; the implementation holds the last value.
  - A RAM with registered output needs a prefetch/bypass register to meet this timing.
- SHOWAHEAD="OFF":
  - q is registered; an accepted read at edge N presents the word after edge N.
  - q holds its value otherwise.
- Data ordering is strict FIFO, with no loss or duplication across pointer wrap-around.
- Intended operating point: the wrapper issues rdreq only when empty=0, and never writes while full.

Test Plan:
- Reset: aclr_n=0 mid-stream -> immediately empty=1, full=0, usedw=0, q=0; after release a write of 0xA5 -> next cycle empty=0, q=0xA5, usedw=1.
- FWFT order: write 1,2,3 on consecutive cycles -> q=1 one cycle after the first write; hold rdreq=1 -> q steps 1,2,3, then empty=1 and usedw=0.
- Fill (AWIDTH=3): write 8 words -> full=1, usedw=0; a 9th write is ignored; read all 8 -> values match, empty=1.
- Simultaneous read/write:
  - at count 4 -> usedw stays 4 and order is preserved;
  - at full -> read accepted, write ignored, usedw=7, full=0;
  - at empty -> write accepted, empty=0 next cycle.
- Wrap-around: 1000 random push/pop cycles with AWIDTH=3 against a scoreboard model -> no mismatch; full and empty agree with model count.
- Underflow: rdreq=1 while empty -> no state change, usedw stays 0, empty stays 1.

Source files
------------

// File: rtl/cge_pkt_fifo_sc.sv
// Single-clock packet FIFO on an inferred RAM: stores opaque DWIDTH words and
// provides registered full/empty/usedw, with show-ahead or registered-read output.
module cge_pkt_fifo_sc #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 11,
    parameter string       SHOWAHEAD = "ON",
    parameter string       LPM_HINT  = "RAM_BLOCK_TYPE=M20K"
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic [DWIDTH-1:0] data,
    input  logic              wrreq,
    input  logic              rdreq,
    output logic [DWIDTH-1:0] q,
    output logic              empty,
    output logic              full,
    output logic [AWIDTH-1:0] usedw
);

    localparam int unsigned DEPTH  = 1 << AWIDTH;
    localparam int unsigned CWIDTH = AWIDTH + 1;
    localparam bit          FWFT   = (SHOWAHEAD == "ON");

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              wr_acc, rd_acc, head_is_new;

    // The RAM hint only steers synthesis; it never alters behaviour.
    if (LPM_HINT == "") begin : g_no_ram_hint
    end

    // Next-state: pointers, count, flags and the output word.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        q_d         = q_q;
        wr_acc      = wrreq && !full_q;
        rd_acc      = rdreq && !empty_q;
        head_is_new = 1'b0;

        if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);

        if (wr_acc && !rd_acc)      count_d = count_q + CWIDTH'(1);
        else if (rd_acc && !wr_acc) count_d = count_q - CWIDTH'(1);

        empty_d = (count_d == CWIDTH'(0));
        full_d  = (count_d == CWIDTH'(DEPTH));

        if (FWFT) begin
            // The new head is the word being written now when nothing older survives this edge.
            head_is_new = wr_acc && (count_q == CWIDTH'(rd_acc));
            if (!empty_d) q_d = head_is_new ? data : mem_q[rd_ptr_d];
        end else if (rd_acc) begin
            q_d = mem_q[rd_ptr_q];
        end
    end

    // Storage array is not reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign q     = q_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign usedw = count_q[AWIDTH-1:0];

endmodule

// File: tb/tb_cge_pkt_fifo_sc.sv
// Directed and scoreboarded checks of cge_pkt_fifo_sc (AWIDTH=3) in show-ahead
// mode, with a registered-read instance fed the same stimulus.
module tb_cge_pkt_fifo_sc;

    logic       clock = 1'b0;
    logic       aclr_n;
    logic [7:0] data;
    logic       wrreq, rdreq;
    logic [7:0] q, q_off;
    logic       empty, full, empty_off, full_off;
    logic [2:0] usedw, usedw_off;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cge_pkt_fifo_sc #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON")) dut (
        .clock(clock), .aclr_n(aclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .empty(empty), .full(full), .usedw(usedw)
    );

    cge_pkt_fifo_sc #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF")) dut_off (
        .clock(clock), .aclr_n(aclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q_off), .empty(empty_off), .full(full_off), .usedw(usedw_off)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (usedw !== 3'd0) begin errors++; $display("FAIL rst_usedw: got %0d want 0", usedw); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: got %0h want 0", q); end
        checks++; if (q_off !== 8'h00 || empty_off !== 1'b1) begin errors++; $display("FAIL rst_off: got q=%0h empty=%b want 0/1", q_off, empty_off); end
        @(negedge clock); aclr_n = 1'b1;
        wrreq = 1'b1; data = 8'h11; tick(); data = 8'h22; tick(); wrreq = 1'b0;
        checks++; if (usedw !== 3'd2) begin errors++; $display("FAIL pre_rst_usedw: got %0d want 2", usedw); end
        #2; aclr_n = 1'b0; #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || usedw !== 3'd0 || q !== 8'h00) begin
            errors++; $display("FAIL midrst: got empty=%b full=%b usedw=%0d q=%0h want 1/0/0/0", empty, full, usedw, q);
        end
        @(negedge clock); aclr_n = 1'b1;
        wrreq = 1'b1; data = 8'hA5; tick(); wrreq = 1'b0;
        checks++; if (empty !== 1'b0 || q !== 8'hA5 || usedw !== 3'd1) begin
            errors++; $display("FAIL post_rst_wr: got empty=%b q=%0h usedw=%0d want 0/a5/1", empty, q, usedw);
        end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_rst_rd: got empty=%b want 1", empty); end
    endtask

    task automatic test_fwft_order();
        wrreq = 1'b1; data = 8'h01; tick();
        checks++; if (q !== 8'h01 || empty !== 1'b0) begin errors++; $display("FAIL fwft_lat: got q=%0h empty=%b want 01/0", q, empty); end
        data = 8'h02; tick(); data = 8'h03; tick(); wrreq = 1'b0;
        checks++; if (usedw !== 3'd3) begin errors++; $display("FAIL fwft_usedw: got %0d want 3", usedw); end
        rdreq = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (q !== 8'(i)) begin errors++; $display("FAIL fwft_q%0d: got %0h want %0h", i, q, i); end
            tick();
            checks++; if (q_off !== 8'(i)) begin errors++; $display("FAIL off_q%0d: got %0h want %0h", i, q_off, i); end
        end
        rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || usedw !== 3'd0) begin errors++; $display("FAIL fwft_drain: got empty=%b usedw=%0d want 1/0", empty, usedw); end
        tick();
        checks++; if (q_off !== 8'h03) begin errors++; $display("FAIL off_hold: got %0h want 03", q_off); end
    endtask

    task automatic test_fill();
        wrreq = 1'b1;
        for (int i = 0; i < 8; i++) begin data = 8'(8'h10 + i); tick(); end
        checks++; if (full !== 1'b1 || usedw !== 3'd0 || empty !== 1'b0) begin
            errors++; $display("FAIL fill_flags: got full=%b usedw=%0d empty=%b want 1/0/0", full, usedw, empty);
        end
        data = 8'hFF; tick(); wrreq = 1'b0;
        checks++; if (full !== 1'b1 || usedw !== 3'd0 || q !== 8'h10) begin
            errors++; $display("FAIL overflow: got full=%b usedw=%0d q=%0h want 1/0/10", full, usedw, q);
        end
        rdreq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (q !== 8'(8'h10 + i)) begin errors++; $display("FAIL fill_rd%0d: got %0h want %0h", i, q, 8'h10 + i); end
            tick();
        end
        rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL fill_empty: got empty=%b full=%b want 1/0", empty, full); end
    endtask

    task automatic test_simultaneous();
        wrreq = 1'b1;
        for (int i = 0; i < 4; i++) begin data = 8'(8'h20 + i); tick(); end
        rdreq = 1'b1; data = 8'h24; tick(); wrreq = 1'b0;
        checks++; if (usedw !== 3'd4 || q !== 8'h21) begin errors++; $display("FAIL sim4: got usedw=%0d q=%0h want 4/21", usedw, q); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (q !== 8'(8'h20 + i)) begin errors++; $display("FAIL sim4_rd%0d: got %0h want %0h", i, q, 8'h20 + i); end
            tick();
        end
        rdreq = 1'b0;
        wrreq = 1'b1;
        for (int i = 0; i < 8; i++) begin data = 8'(8'h30 + i); tick(); end
        rdreq = 1'b1; data = 8'h99; tick(); wrreq = 1'b0;
        checks++; if (usedw !== 3'd7 || full !== 1'b0 || q !== 8'h31) begin
            errors++; $display("FAIL simfull: got usedw=%0d full=%b q=%0h want 7/0/31", usedw, full, q);
        end
        for (int i = 1; i <= 7; i++) begin
            checks++; if (q !== 8'(8'h30 + i)) begin errors++; $display("FAIL simfull_rd%0d: got %0h want %0h", i, q, 8'h30 + i); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simfull_empty: got %b want 1", empty); end
        wrreq = 1'b1; data = 8'h42; tick(); wrreq = 1'b0; rdreq = 1'b0;
        checks++; if (empty !== 1'b0 || q !== 8'h42 || usedw !== 3'd1) begin
            errors++; $display("FAIL simempty: got empty=%b q=%0h usedw=%0d want 0/42/1", empty, q, usedw);
        end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
    endtask

    task automatic test_underflow();
        rdreq = 1'b1; tick(); tick(); rdreq = 1'b0;
        checks++; if (empty !== 1'b1 || usedw !== 3'd0 || full !== 1'b0) begin
            errors++; $display("FAIL underflow: got empty=%b usedw=%0d full=%b want 1/0/0", empty, usedw, full);
        end
        wrreq = 1'b1; data = 8'h55; tick(); wrreq = 1'b0;
        checks++; if (q !== 8'h55 || usedw !== 3'd1) begin errors++; $display("FAIL underflow_wr: got q=%0h usedw=%0d want 55/1", q, usedw); end
        rdreq = 1'b1; tick(); rdreq = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] model[$];
        logic [7:0] off_exp;
        logic       wa, ra;
        aclr_n = 1'b0; #2; aclr_n = 1'b1;
        off_exp = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            wrreq = 1'($urandom_range(0, 1));
            rdreq = 1'($urandom_range(0, 1));
            data  = 8'($urandom);
            checks++; if (empty !== (model.size() == 0) || full !== (model.size() == 8) || usedw !== 3'(model.size())) begin
                errors++; $display("FAIL rnd_flags@%0d: got empty=%b full=%b usedw=%0d want count %0d", i, empty, full, usedw, model.size());
            end
            if (model.size() != 0) begin
                checks++; if (q !== model[0]) begin errors++; $display("FAIL rnd_q@%0d: got %0h want %0h", i, q, model[0]); end
            end
            checks++; if (q_off !== off_exp) begin errors++; $display("FAIL rnd_qoff@%0d: got %0h want %0h", i, q_off, off_exp); end
            wa = wrreq && (model.size() < 8);
            ra = rdreq && (model.size() > 0);
            if (ra) off_exp = model.pop_front();
            if (wa) model.push_back(data);
            tick();
        end
        wrreq = 1'b0; rdreq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwft_order();
        test_fill();
        test_simultaneous();
        test_underflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
